sw_debounce: RTL and testbench

Multi-bit switch/button conditioner between the board `sw` pins and the NOEL-V GPIO input bus (`gpioi`). Each bit is synchronised to `sys_clk` with a two-flop synchroniser, then filtered so it changes only after it has been stable for a programmable number of cycles. Per-bit rise and fall strobes and a sticky change flag with a clear handshake let software or the LED logic detect edges without polling raw pins.

---
 rtl/sw_debounce.sv | 99 +++++++++
 tb/tb_sw_debounce.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// Multi-bit switch conditioner: 2-flop synchroniser plus stable-count filter per bit,
// with registered rise/fall strobes and a sticky change flag with per-bit clear.

module sw_debounce_lane #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic sys_clk,
  input  logic rstn,
  input  logic raw_i,
  input  logic clr_i,
  output logic db_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_o
);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d, fall_q, fall_d;
  logic             chg_q, chg_d;

  // Any return of s2 to the settled level drops the partial count.
  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    db_d   = db_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == TERM) begin
      cnt_d  = '0;
      db_d   = s2_q;
      rise_d = s2_q;
      fall_d = ~s2_q;
    end
    // A new strobe wins over a simultaneous clear.
    chg_d = (rise_d | fall_d) ? 1'b1 : (clr_i ? 1'b0 : chg_q);
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      chg_q  <= 1'b0;
    end else begin
      s1_q   <= raw_i;
      s2_q   <= s1_q;
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      chg_q  <= chg_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  assign chg_o  = chg_q;
endmodule

module sw_debounce #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             sys_clk,
  input  logic             rstn,
  input  logic [WIDTH-1:0] raw_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] db_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] chg_o
);
  // Bits share no state; one independent lane per input.
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    sw_debounce_lane #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_lane (
      .sys_clk(sys_clk),
      .rstn   (rstn),
      .raw_i  (raw_i[g]),
      .clr_i  (clr_i[g]),
      .db_o   (db_o[g]),
      .rise_o (rise_o[g]),
      .fall_o (fall_o[g]),
      .chg_o  (chg_o[g])
    );
  end
endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce at WIDTH=4, DEBOUNCE_CYCLES=4 (6-edge latency).

module tb_sw_debounce;
  localparam int W = 4;

  logic         sys_clk = 1'b0;
  logic         rstn    = 1'b0;
  logic [W-1:0] raw_i   = '0;
  logic [W-1:0] clr_i   = '0;
  logic [W-1:0] db_o, rise_o, fall_o, chg_o;

  int errors = 0;
  int checks = 0;

  sw_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(4)) dut (
    .sys_clk(sys_clk),
    .rstn   (rstn),
    .raw_i  (raw_i),
    .clr_i  (clr_i),
    .db_o   (db_o),
    .rise_o (rise_o),
    .fall_o (fall_o),
    .chg_o  (chg_o)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge sys_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rstn  = 1'b0;
    raw_i = '0;
    clr_i = '0;
    #2;
    rstn = 1'b1;
    step(3);
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    raw_i = 4'hF;
    step(3);
    checks++;
    if ({db_o, rise_o, fall_o, chg_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_hold: db=%h rise=%h fall=%h chg=%h, want all 0", db_o, rise_o, fall_o, chg_o);
    end
    rstn = 1'b1;
    step(5);
    checks++;
    if (db_o !== 4'h0 || rise_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_edge5: db=%h rise=%h, want 0 0", db_o, rise_o);
    end
    step(1);
    checks++;
    if (db_o !== 4'hF || rise_o !== 4'hF || fall_o !== 4'h0 || chg_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_edge6: db=%h rise=%h fall=%h chg=%h, want F F 0 F", db_o, rise_o, fall_o, chg_o);
    end
    step(1);
    checks++;
    if (db_o !== 4'hF || rise_o !== 4'h0 || chg_o !== 4'hF) begin
      errors++;
      $display("FAIL reset_edge7: db=%h rise=%h chg=%h, want F 0 F", db_o, rise_o, chg_o);
    end
  endtask

  task automatic test_glitch();
    do_reset();
    raw_i = 4'h1;
    for (int k = 1; k <= 10; k++) begin
      if (k == 4) raw_i = 4'h0;
      step(1);
      checks++;
      if (db_o[0] !== 1'b0 || rise_o[0] !== 1'b0) begin
        errors++;
        $display("FAIL glitch3 k=%0d: db0=%b rise0=%b, want 0 0", k, db_o[0], rise_o[0]);
      end
    end
    raw_i = 4'h1;
    step(4);
    raw_i = 4'h0;
    step(1);
    checks++;
    if (db_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch4_early: db0=%b, want 0", db_o[0]);
    end
    step(1);
    checks++;
    if (db_o[0] !== 1'b1 || rise_o[0] !== 1'b1) begin
      errors++;
      $display("FAIL glitch4_accept: db0=%b rise0=%b, want 1 1", db_o[0], rise_o[0]);
    end
    step(1);
    checks++;
    if (rise_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch4_pulse: rise0=%b, want 0", rise_o[0]);
    end
  endtask

  task automatic test_bounce();
    logic [W-1:0] seq [5];
    seq = '{4'h2, 4'h0, 4'h2, 4'h0, 4'h2};
    do_reset();
    for (int t = 0; t < 4; t++) begin
      raw_i = seq[t];
      step(1);
      checks++;
      if (rise_o[1] !== 1'b0 || db_o[1] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_toggle t=%0d: rise1=%b db1=%b, want 0 0", t, rise_o[1], db_o[1]);
      end
    end
    raw_i = seq[4];
    for (int k = 1; k <= 10; k++) begin
      step(1);
      checks++;
      if (rise_o[1] !== (k == 6) || db_o[1] !== (k >= 6)) begin
        errors++;
        $display("FAIL bounce_hold k=%0d: rise1=%b db1=%b, want %b %b", k, rise_o[1], db_o[1], k == 6, k >= 6);
      end
    end
  endtask

  task automatic test_fall_clear();
    do_reset();
    raw_i = 4'h4;
    step(6);
    clr_i = 4'h4;
    step(1);
    clr_i = 4'h0;
    checks++;
    if (db_o[2] !== 1'b1 || chg_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_after_rise: db2=%b chg2=%b, want 1 0", db_o[2], chg_o[2]);
    end
    raw_i = 4'h0;
    step(5);
    checks++;
    if (fall_o[2] !== 1'b0 || chg_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL fall_early: fall2=%b chg2=%b, want 0 0", fall_o[2], chg_o[2]);
    end
    step(1);
    checks++;
    if (fall_o !== 4'h4 || rise_o !== 4'h0 || db_o[2] !== 1'b0 || chg_o !== 4'h4) begin
      errors++;
      $display("FAIL fall_strobe: fall=%h rise=%h db2=%b chg=%h, want 4 0 0 4", fall_o, rise_o, db_o[2], chg_o);
    end
    step(1);
    checks++;
    if (fall_o[2] !== 1'b0 || chg_o[2] !== 1'b1) begin
      errors++;
      $display("FAIL fall_sticky: fall2=%b chg2=%b, want 0 1", fall_o[2], chg_o[2]);
    end
    clr_i = 4'h4;
    step(1);
    clr_i = 4'h0;
    checks++;
    if (chg_o[2] !== 1'b0) begin
      errors++;
      $display("FAIL clr_after_fall: chg2=%b, want 0", chg_o[2]);
    end
    raw_i = 4'h4;
    step(5);
    clr_i = 4'h5;
    step(1);
    clr_i = 4'h0;
    checks++;
    if (rise_o !== 4'h4 || chg_o !== 4'h4) begin
      errors++;
      $display("FAIL set_over_clr: rise=%h chg=%h, want 4 4", rise_o, chg_o);
    end
    step(1);
    checks++;
    if (chg_o !== 4'h4) begin
      errors++;
      $display("FAIL set_over_clr_hold: chg=%h, want 4", chg_o);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    raw_i = 4'h1;
    step(6);
    raw_i = 4'h9;
    step(4);
    rstn = 1'b0;
    #1;
    checks++;
    if ({db_o, rise_o, fall_o, chg_o} !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_async: db=%h rise=%h fall=%h chg=%h, want all 0", db_o, rise_o, fall_o, chg_o);
    end
    rstn = 1'b1;
    step(5);
    checks++;
    if (db_o !== 4'h0 || rise_o !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid_edge5: db=%h rise=%h, want 0 0", db_o, rise_o);
    end
    step(1);
    checks++;
    if (db_o !== 4'h9 || rise_o !== 4'h9 || chg_o !== 4'h9) begin
      errors++;
      $display("FAIL reset_mid_edge6: db=%h rise=%h chg=%h, want 9 9 9", db_o, rise_o, chg_o);
    end
  endtask

  task automatic test_parallel();
    do_reset();
    raw_i = 4'hA;
    step(5);
    checks++;
    if (db_o !== 4'h0 || rise_o !== 4'h0) begin
      errors++;
      $display("FAIL parallel_early: db=%h rise=%h, want 0 0", db_o, rise_o);
    end
    step(1);
    checks++;
    if (db_o !== 4'hA || rise_o !== 4'hA || fall_o !== 4'h0) begin
      errors++;
      $display("FAIL parallel_rise: db=%h rise=%h fall=%h, want A A 0", db_o, rise_o, fall_o);
    end
    raw_i = 4'h5;
    step(6);
    checks++;
    if (db_o !== 4'h5 || rise_o !== 4'h5 || fall_o !== 4'hA || chg_o !== 4'hF) begin
      errors++;
      $display("FAIL parallel_swap: db=%h rise=%h fall=%h chg=%h, want 5 5 A F", db_o, rise_o, fall_o, chg_o);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_bounce();
    test_fall_clear();
    test_reset_mid();
    test_parallel();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
